piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in/serial-out framing transmitter that feeds the team's serial-in/serial-out shift-register stage. It accepts a parallel word over a valid/ready handshake and serializes it one bit per bit-period as start bit, data LSB-first, optional parity and stop bit. The `so` output drives the downstream stage's serial input directly; idle level is 0, matching that stage's reset value.

## Interface
- `WIDTH`, default 4: data bits per word, minimum 1.
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit, minimum 1.
- `PARITY_EN`, default 1: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset).
- `din` in WIDTH: parallel word, sampled only on an accepted handshake.
- `din_valid` in 1: upstream has a word.
- `din_ready` out 1: block can accept a word this cycle.
- `so` out 1: serial output, registered.
- `so_valid` out 1: high while `so` carries a frame bit, registered.
- `busy` out 1: frame in progress (state ≠ IDLE).

## Operation
- Frame is L = 2 + WIDTH + PARITY_EN bits: start = 1, then `din[0]`…`din[WIDTH-1]`, then parity (if enabled), then stop = 0.
- Parity: even gives XOR of all data bits; odd gives the inverted XOR. It is computed from the captured word, not from live `din`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on accept.
  - START → DATA after one bit-period.
  - DATA → PARITY (or STOP if `PARITY_EN` = 0) after WIDTH bit-periods; a bit counter runs 0..WIDTH-1.
  - PARITY → STOP after one bit-period.
  - STOP → IDLE after one bit-period, or → START if an accept occurs on STOP's last cycle.
- Accept = `din_valid` & `din_ready` at a rising edge. On accept, `din` is captured into an internal shift register.
- `din_ready` = 1 in IDLE, and on the final clock of STOP. This allows back-to-back frames with no idle gap. `din_ready` is forced 0 while `rst` = 0.
- `din_valid` without `din_ready` is ignored; no word is lost or duplicated.
- A bit-period counter counts 0..CLKS_PER_BIT-1. State and bit advance when it wraps.
- Outside a frame: `so` = 0, `so_valid` = 0.

## Timing
- Reset values: `so` = 0, `so_valid` = 0, `busy` = 0, `din_ready` = 0 during reset, FSM = IDLE, all counters = 0.
- Reset mid-frame: outputs go to reset values asynchronously and the frame is discarded. After `rst` deasserts, `din_ready` = 1 in the same cycle (IDLE).
- Latency: with accept at edge N, `so` = start bit from edge N. Data bit k is presented from edge N + (1+k)·CLKS_PER_BIT. Stop bit ends at edge N + L·CLKS_PER_BIT.
- `so_valid` and `busy` rise at edge N and fall at edge N + L·CLKS_PER_BIT, unless a back-to-back accept occurs, in which case they stay high.
- Throughput: one word per L·CLKS_PER_BIT cycles when `din_valid` is held high.
- Changes to `din` after accept have no effect on the frame in flight.

## Structure
- Shared package `piso_tx_pkg` holds the FSM state enum (IDLE, START, DATA, PARITY, STOP) and the constants `START_BIT` = 1, `STOP_BIT` = 0, `IDLE_LEVEL` = 0.
- One sub-module, `bit_timer`: parameterized by CLKS_PER_BIT, with `clk`/`rst`, an `en` input and a `tick` output. `tick` pulses on the last cycle of each bit-period and is cleared on accept.
- The top module holds the FSM, data shift register, bit counter, parity register and output registers.

## Test plan
- Reset: hold `rst` = 0 with `din_valid` = 1 → `so` = 0, `so_valid` = 0, `busy` = 0, `din_ready` = 0. After release, `din_ready` = 1.
- Single frame (WIDTH 4, CLKS_PER_BIT 1, even parity): `din` = 4'b1011, one-cycle valid → `so` = 1,1,1,0,1,1,0 on 7 consecutive cycles, `so_valid` high for exactly 7 cycles, then `so` = 0.
- Back-to-back: `din_valid` held high with 4'b1011 then 4'b0000 → 14 contiguous `so_valid` cycles. Second frame is 1,0,0,0,0,0,0. `din_ready` pulses on cycles 0 and 6.
- Bit period: CLKS_PER_BIT = 3, `din` = 4'b0001, odd parity → each bit held 3 cycles. Sequence 1,1,0,0,0,0,0 (odd parity of one 1 = 0). Frame lasts 21 cycles.
- Reset mid-frame: assert `rst` during data bit 2 of 4'b1111 → `so` and `so_valid` drop to 0 without waiting for an edge. A new word 4'b0101 accepted after release → clean frame 1,1,0,1,0,0,0.
- Stall: `din_valid` asserted during `busy` with `din` changing → captured word is unaffected. The next accept takes the `din` value present on STOP's last cycle.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared types and line-level constants for the framing transmitter.
package piso_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Line levels. The stop level equals the idle level. For that reason, so_valid,
  // not so, marks where a frame ends.
  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/piso_tx_bit_timer.sv
// Bit-period timer: tick marks the last clock of each serial bit.
module bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // The count is held at 0 while disabled, so every accept from IDLE starts a fresh period.
  // A back-to-back accept lands on the wrap, which also leaves the count at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              cnt <= '0;
    else if (!en)          cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out framing transmitter.
// Frame format: start, data LSB first, optional parity, stop.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_valid,
  output logic             busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic PAR_INV = (PARITY_ODD != 0);

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [BW-1:0]    bitcnt;
  logic             par;
  logic             tick;
  logic             acc;

  assign busy = (state != IDLE);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .tick (tick)
  );

  // Ready in IDLE, and on the last clock of STOP so frames can run back to back.
  // Gating with rst keeps ready low while reset is held.
  assign din_ready = rst & ((state == IDLE) | ((state == STOP) & tick));
  assign acc       = din_valid & din_ready;

  // Framing FSM. The output registers present each bit from the edge that enters its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sh       <= '0;
      bitcnt   <= '0;
      par      <= 1'b0;
      so       <= IDLE_LEVEL;
      so_valid <= 1'b0;
    end else if (acc) begin
      // Capture the word and its parity. Later changes on din cannot touch this frame.
      state    <= START;
      sh       <= din;
      par      <= (^din) ^ PAR_INV;
      bitcnt   <= '0;
      so       <= START_BIT;
      so_valid <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          so       <= IDLE_LEVEL;
          so_valid <= 1'b0;
        end
        START: if (tick) begin
          state  <= DATA;
          so     <= sh[0];
          sh     <= sh >> 1;
          bitcnt <= '0;
        end
        DATA: if (tick) begin
          if (bitcnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state <= PARITY;
              so    <= par;
            end else begin
              state <= STOP;
              so    <= STOP_BIT;
            end
          end else begin
            so     <= sh[0];
            sh     <= sh >> 1;
            bitcnt <= bitcnt + 1'b1;
          end
        end
        PARITY: if (tick) begin
          state <= STOP;
          so    <= STOP_BIT;
        end
        STOP: if (tick) begin
          state    <= IDLE;
          so       <= IDLE_LEVEL;
          so_valid <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          so       <= IDLE_LEVEL;
          so_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx.
// u0 uses the default parameters (CLKS_PER_BIT = 1, even parity).
// u1 uses CLKS_PER_BIT = 3 with odd parity.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din0, din1;
  logic       dv0, dv1;
  logic       rdy0, rdy1, so0, so1, sv0, sv1, busy0, busy1;

  always #5 clk = ~clk;

  piso_tx u0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(dv0), .din_ready(rdy0),
    .so(so0), .so_valid(sv0), .busy(busy0)
  );

  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .din_ready(rdy1),
    .so(so1), .so_valid(sv1), .busy(busy1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // seq is written in transmission order, left to right; bit i is seq[6-i].
  task automatic check_frame0(input string tag, input logic [6:0] seq);
    for (int i = 0; i < 7; i++) begin
      chk({tag, " so"}, 32'(so0), 32'(seq[6-i]));
      chk({tag, " so_valid"}, 32'(sv0), 32'd1);
      step();
    end
  endtask

  initial begin
    logic [6:0] f1, f2, fs, f3, fr;
    f1 = 7'b1110110; // 4'b1011, even parity 1
    f2 = 7'b1000000; // 4'b0000
    fs = 7'b1011000; // 4'b0110
    f3 = 7'b1100000; // 4'b0001, odd parity 0
    fr = 7'b1101000; // 4'b0101

    // Reset held with valid asserted.
    rst = 1'b0; dv0 = 1'b1; din0 = 4'hf; dv1 = 1'b1; din1 = 4'hf;
    repeat (3) step();
    chk("rst so", 32'(so0), 0);
    chk("rst so_valid", 32'(sv0), 0);
    chk("rst busy", 32'(busy0), 0);
    chk("rst din_ready", 32'(rdy0), 0);
    chk("rst din_ready u1", 32'(rdy1), 0);
    dv0 = 1'b0; dv1 = 1'b0;
    rst = 1'b1;
    #1;
    chk("post-rst din_ready", 32'(rdy0), 1);

    // Single frame.
    din0 = 4'b1011; dv0 = 1'b1;
    step();
    dv0 = 1'b0; din0 = 4'b0000;
    chk("single ready in START", 32'(rdy0), 0);
    chk("single busy", 32'(busy0), 1);
    check_frame0("single", f1);
    chk("single end so_valid", 32'(sv0), 0);
    chk("single end so", 32'(so0), 0);
    chk("single end busy", 32'(busy0), 0);

    // Back-to-back frames.
    din0 = 4'b1011; dv0 = 1'b1;
    chk("b2b ready c0", 32'(rdy0), 1);
    step();
    din0 = 4'b0000;
    for (int i = 0; i < 14; i++) begin
      chk("b2b so", 32'(so0), 32'(i < 7 ? f1[6-i] : f2[13-i]));
      chk("b2b so_valid", 32'(sv0), 1);
      chk("b2b din_ready", 32'(rdy0), 32'(i == 6 || i == 13));
      if (i == 7) dv0 = 1'b0;
      step();
    end
    chk("b2b end so_valid", 32'(sv0), 0);

    // Stall: valid held with din wandering while busy.
    din0 = 4'b1011; dv0 = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      chk("stall so", 32'(so0), 32'(f1[6-i]));
      chk("stall din_ready", 32'(rdy0), 32'(i == 6));
      din0 = (i == 6) ? 4'b0110 : 4'(i * 5 + 4);
      step();
    end
    dv0 = 1'b0; din0 = 4'b1111;
    check_frame0("stall next", fs);
    chk("stall end so_valid", 32'(sv0), 0);

    // Bit period of 3 clocks with odd parity.
    din1 = 4'b0001; dv1 = 1'b1;
    step();
    dv1 = 1'b0; din1 = 4'b1111;
    for (int i = 0; i < 21; i++) begin
      chk("cpb3 so", 32'(so1), 32'(f3[6-i/3]));
      chk("cpb3 so_valid", 32'(sv1), 1);
      step();
    end
    chk("cpb3 end so_valid", 32'(sv1), 0);
    chk("cpb3 end busy", 32'(busy1), 0);

    // Reset mid-frame, during data bit 2.
    din0 = 4'b1111; dv0 = 1'b1;
    step();
    dv0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("midrst pre so", 32'(so0), 1);
      if (i < 3) step();
    end
    #2 rst = 1'b0;
    #1;
    chk("midrst so", 32'(so0), 0);
    chk("midrst so_valid", 32'(sv0), 0);
    chk("midrst busy", 32'(busy0), 0);
    chk("midrst din_ready", 32'(rdy0), 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst release ready", 32'(rdy0), 1);
    din0 = 4'b0101; dv0 = 1'b1;
    step();
    dv0 = 1'b0;
    check_frame0("recover", fr);
    chk("recover end so_valid", 32'(sv0), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
